// File: rtl/game_status_tracker.sv
// game_status_tracker: per-level gameplay status for the screen-phase controller.
// Turns gameplay events and the frame tick into mario_alive / game_end, and owns
// the lives count, the BCD level timer, and the death / invulnerability windows.
module game_status_tracker #(
  parameter int unsigned  START_LIVES     = 3,
  parameter logic [11:0]  START_TIME      = 12'h400,
  parameter int unsigned  FRAMES_PER_TICK = 24,
  parameter int unsigned  DEATH_FRAMES    = 120,
  parameter int unsigned  INVULN_FRAMES   = 90
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        frame_tick,
  input  logic        game_active,
  input  logic        enemy_hit,
  input  logic        powered,
  input  logic        pit_fall,
  input  logic        flag_reached,
  output logic        mario_alive,
  output logic        game_end,
  output logic [2:0]  lives,
  output logic [11:0] time_bcd,
  output logic        death_anim,
  output logic        invuln,
  output logic        shrink,
  output logic        respawn
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] FPT_C   = CW'(FRAMES_PER_TICK);
  localparam logic [CW-1:0] DEATH_C = CW'(DEATH_FRAMES);
  localparam logic [CW-1:0] INV_C   = CW'(INVULN_FRAMES);
  localparam logic [2:0]    LIVES_C = 3'(START_LIVES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_INVULN  = 3'd2,
    ST_DYING   = 3'd3,
    ST_RESPAWN = 3'd4,
    ST_CLEAR   = 3'd5,
    ST_OVER    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tcnt_q, tcnt_d;   // frames toward the next timer decrement
  logic [CW-1:0] pcnt_q, pcnt_d;   // frames spent in INVULN or DYING
  logic [11:0]   time_q, time_d;
  logic [2:0]    lives_q, lives_d;
  logic          shrink_d;
  logic          alive_q, end_q, anim_q, inv_q, shrink_q, resp_q;

  // Three-digit BCD decrement with borrow chain, saturating at 000.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h000) begin
      r = 12'h000;
    end else if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4]  = 4'd9;
        r[11:8] = v[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  // Next-state, counter, timer and lives logic; events beat a same-cycle tick.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    pcnt_d   = pcnt_q;
    time_d   = time_q;
    lives_d  = lives_q;
    shrink_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lives_d = LIVES_C;
        time_d  = START_TIME;
        tcnt_d  = {CW{1'b0}};
        pcnt_d  = {CW{1'b0}};
        if (game_active) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_INVULN: begin
        if (!game_active) begin
          state_d = state_q;            // paused: everything frozen
        end else if (flag_reached) begin
          state_d = ST_CLEAR;
          tcnt_d  = {CW{1'b0}};
          pcnt_d  = {CW{1'b0}};
        end else if (pit_fall) begin
          state_d = ST_DYING;
          tcnt_d  = {CW{1'b0}};
          pcnt_d  = {CW{1'b0}};
        end else if (enemy_hit && (state_q == ST_RUN)) begin
          if (powered) begin
            shrink_d = 1'b1;
            state_d  = ST_INVULN;
          end else begin
            state_d  = ST_DYING;
          end
          tcnt_d = {CW{1'b0}};
          pcnt_d = {CW{1'b0}};
        end else if (time_q == 12'h000) begin
          state_d = ST_DYING;
          tcnt_d  = {CW{1'b0}};
          pcnt_d  = {CW{1'b0}};
        end else if (frame_tick) begin
          if (tcnt_q + 16'd1 == FPT_C) begin
            tcnt_d = {CW{1'b0}};
            time_d = bcd_dec(time_q);
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
          if (state_q == ST_INVULN) begin
            if (pcnt_q + 16'd1 == INV_C) begin
              state_d = ST_RUN;
              pcnt_d  = {CW{1'b0}};
            end else begin
              pcnt_d  = pcnt_q + 16'd1;
            end
          end else begin
            pcnt_d = pcnt_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DYING: begin
        if (frame_tick) begin
          if (pcnt_q + 16'd1 == DEATH_C) begin
            lives_d = lives_q - 3'd1;
            pcnt_d  = {CW{1'b0}};
            if (lives_q == 3'd1) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_RESPAWN;
              time_d  = START_TIME;
              tcnt_d  = {CW{1'b0}};
            end
          end else begin
            pcnt_d = pcnt_q + 16'd1;
          end
        end else begin
          state_d = ST_DYING;
        end
      end
      ST_RESPAWN: begin
        state_d = ST_RUN;
      end
      ST_CLEAR: begin
        state_d = ST_CLEAR;
      end
      ST_OVER: begin
        state_d = ST_OVER;
        lives_d = 3'd0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; RESET wins in every state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      tcnt_q   <= {CW{1'b0}};
      pcnt_q   <= {CW{1'b0}};
      time_q   <= START_TIME;
      lives_q  <= LIVES_C;
      alive_q  <= 1'b1;
      end_q    <= 1'b0;
      anim_q   <= 1'b0;
      inv_q    <= 1'b0;
      shrink_q <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      pcnt_q   <= pcnt_d;
      time_q   <= time_d;
      lives_q  <= lives_d;
      alive_q  <= (state_d != ST_OVER);
      end_q    <= (state_d == ST_CLEAR);
      anim_q   <= (state_d == ST_DYING);
      inv_q    <= (state_d == ST_INVULN);
      shrink_q <= shrink_d;
      resp_q   <= (state_d == ST_RESPAWN);
    end
  end

  assign mario_alive = alive_q;
  assign game_end    = end_q;
  assign lives       = lives_q;
  assign time_bcd    = time_q;
  assign death_anim  = anim_q;
  assign invuln      = inv_q;
  assign shrink      = shrink_q;
  assign respawn     = resp_q;

endmodule

// File: tb/tb_game_status_tracker.sv
// Scoreboard bench for game_status_tracker: stimulus pushes hand-computed
// output vectors after each edge; a negedge monitor pops and compares them.
module tb_game_status_tracker;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        frame_tick = 1'b0;
  logic        game_active = 1'b0;
  logic        enemy_hit = 1'b0;
  logic        powered = 1'b0;
  logic        pit_fall = 1'b0;
  logic        flag_reached = 1'b0;
  logic        mario_alive, game_end, death_anim, invuln, shrink, respawn;
  logic [2:0]  lives;
  logic [11:0] time_bcd;

  int checks = 0;
  int passed = 0;

  string       name_q[$];
  logic [20:0] vec_q[$];

  game_status_tracker #(
    .START_LIVES(2), .START_TIME(12'h010), .FRAMES_PER_TICK(2),
    .DEATH_FRAMES(3), .INVULN_FRAMES(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .game_active(game_active),
    .enemy_hit(enemy_hit), .powered(powered), .pit_fall(pit_fall),
    .flag_reached(flag_reached), .mario_alive(mario_alive), .game_end(game_end),
    .lives(lives), .time_bcd(time_bcd), .death_anim(death_anim), .invuln(invuln),
    .shrink(shrink), .respawn(respawn)
  );

  always #5 CLK = ~CLK;

  // {alive, end, lives, time, death_anim, invuln, shrink, respawn}
  function automatic logic [20:0] mk(input logic a, input logic e, input logic [2:0] l,
                                     input logic [11:0] t, input logic da, input logic iv,
                                     input logic sh, input logic rs);
    return {a, e, l, t, da, iv, sh, rs};
  endfunction

  // Monitor: compare every pending expectation against the outputs at negedge.
  always @(negedge CLK) begin
    logic [20:0] got;
    got = {mario_alive, game_end, lives, time_bcd, death_anim, invuln, shrink, respawn};
    while (vec_q.size() > 0) begin
      string       nm;
      logic [20:0] ex;
      nm = name_q.pop_front();
      ex = vec_q.pop_front();
      checks++;
      if (got === ex) begin
        passed++;
      end else begin
        $display("FAIL %s: got alive=%b end=%b lives=%0d time=%h anim=%b inv=%b shr=%b resp=%b, expected alive=%b end=%b lives=%0d time=%h anim=%b inv=%b shr=%b resp=%b",
                 nm, got[20], got[19], got[18:16], got[15:4], got[3], got[2], got[1], got[0],
                 ex[20], ex[19], ex[18:16], ex[15:4], ex[3], ex[2], ex[1], ex[0]);
      end
    end
  end

  task automatic step(input logic ft, input logic eh, input logic pf, input logic fr);
    frame_tick = ft; enemy_hit = eh; pit_fall = pf; flag_reached = fr;
    @(posedge CLK); #1;
    frame_tick = 1'b0; enemy_hit = 1'b0; pit_fall = 1'b0; flag_reached = 1'b0;
  endtask

  task automatic expect_vec(input string nm, input logic [20:0] v);
    name_q.push_back(nm);
    vec_q.push_back(v);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    expect_vec("reset", mk(1'b1, 1'b0, 3'd2, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int m;
    logic [11:0] t;

    // Timer countdown from 010 to 000, then death and respawn
    do_reset();
    game_active = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_vec("enter_run", mk(1'b1, 1'b0, 3'd2, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      m = 10 - k / 2;
      t = (m == 10) ? 12'h010 : {8'h00, 4'(m)};
      expect_vec("countdown", mk(1'b1, 1'b0, 3'd2, t, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_vec("expiry_dying", mk(1'b1, 1'b0, 3'd2, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_vec("dying_hold", mk(1'b1, 1'b0, 3'd2, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_vec("respawn", mk(1'b1, 1'b0, 3'd1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_vec("run_after_respawn", mk(1'b1, 1'b0, 3'd1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0));

    // Powered hit: shrink pulse, invulnerability, second hit ignored
    powered = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_vec("shrink", mk(1'b1, 1'b0, 3'd1, 12'h010, 1'b0, 1'b1, 1'b1, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_vec("shrink_once", mk(1'b1, 1'b0, 3'd1, 12'h010, 1'b0, 1'b1, 1'b0, 1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_vec("invuln_timer", mk(1'b1, 1'b0, 3'd1, 12'h009, 1'b0, 1'b1, 1'b0, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_vec("invuln_hit_ignored", mk(1'b1, 1'b0, 3'd1, 12'h009, 1'b0, 1'b1, 1'b0, 1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_vec("invuln_3rd", mk(1'b1, 1'b0, 3'd1, 12'h009, 1'b0, 1'b1, 1'b0, 1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_vec("invuln_exit", mk(1'b1, 1'b0, 3'd1, 12'h008, 1'b0, 1'b0, 1'b0, 1'b0));

    // Pause: six ticks and an unpowered hit with game_active low
    powered = 1'b0;
    game_active = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, (k == 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      expect_vec("pause", mk(1'b1, 1'b0, 3'd1, 12'h008, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    game_active = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_vec("resume_1", mk(1'b1, 1'b0, 3'd1, 12'h008, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_vec("resume_2", mk(1'b1, 1'b0, 3'd1, 12'h007, 1'b0, 1'b0, 1'b0, 1'b0));

    // Game over: two unpowered hits, each death run to completion
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_vec("hit1_dying", mk(1'b1, 1'b0, 3'd2, 12'h010, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_vec("hit1_respawn", mk(1'b1, 1'b0, 3'd1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    expect_vec("hit2_dying", mk(1'b1, 1'b0, 3'd1, 12'h010, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_vec("game_over", mk(1'b0, 1'b0, 3'd0, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 10; k++) begin
      step(1'b1, k[0], k[1], k[2]);
      expect_vec("over_hold", mk(1'b0, 1'b0, 3'd0, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    // Simultaneous flag and pit with a tick: level cleared, timer frozen
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    expect_vec("clear", mk(1'b1, 1'b1, 3'd2, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      expect_vec("clear_hold", mk(1'b1, 1'b1, 3'd2, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    // Reset during DYING
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    expect_vec("pit_dying", mk(1'b1, 1'b0, 3'd2, 12'h010, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    game_active = 1'b0;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_vec("idle_after_reset", mk(1'b1, 1'b0, 3'd2, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0));

    @(negedge CLK); #1;
    if (vec_q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending, expected 0", vec_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
